// File: rtl/suite_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : suite_pattern_gen
// Purpose  : Parametrised 240p raster generator with four selectable patterns.
// Options  : SUITE_DRIFT_EN - pattern 3 becomes a bar drifting one column/frame
// Revision : 1.0 - initial release
// ============================================================================
module suite_pattern_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 13,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 35,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 8,
  parameter int V_BP     = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pattern_sel,
  output logic       ce_pix,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic       frame_start,
  output logic [7:0] video
);

  localparam int         c_HTOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_VTOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [3:0] c_DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] c_H_LAST   = 10'(c_HTOTAL - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_VTOTAL - 1);
  localparam logic [9:0] c_HA       = 10'(H_ACTIVE);
  localparam logic [9:0] c_VA       = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] c_BAR_LAST = 10'(H_ACTIVE / 8 - 1);
  localparam int         c_HC       = H_ACTIVE / 2;
  localparam int         c_VC       = V_ACTIVE / 2;

  logic [3:0] r_div;
  logic       r_ce;
  logic [9:0] r_hc, r_vc, r_sub;
  logic [2:0] r_bar;
  logic [1:0] r_sel;
  logic       r_hblank, r_hsync, r_vblank, r_vsync, r_fstart;
  logic [7:0] r_video;

  logic       w_h_end, w_v_end, w_blank, w_white, w_title;
  logic [7:0] w_grid, w_ramp, w_check, w_flat, w_luma;
  int         w_x, w_y;

  function automatic logic f_outline(input int x, input int y, input int l,
                                     input int r, input int t, input int b);
    return ((x == l || x == r) && y >= t && y <= b) ||
           ((y == t || y == b) && x >= l && x <= r);
  endfunction

  assign w_h_end = (r_hc == c_H_LAST);
  assign w_v_end = (r_vc == c_V_LAST);
  assign w_blank = (r_hc >= c_HA) || (r_vc >= c_VA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= 4'd0;
      r_ce  <= 1'b0;
    end else begin
      r_ce  <= (r_div == c_DIV_LAST);
      r_div <= (r_div == c_DIV_LAST) ? 4'd0 : r_div + 4'd1;
    end
  end

  // r_sub/r_bar track r_hc so the ramp needs no divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hc  <= 10'd0;
      r_vc  <= 10'd0;
      r_sub <= 10'd0;
      r_bar <= 3'd0;
      r_sel <= 2'd0;
    end else if (r_ce) begin
      if (w_h_end) begin
        r_hc  <= 10'd0;
        r_sub <= 10'd0;
        r_bar <= 3'd0;
        r_vc  <= w_v_end ? 10'd0 : r_vc + 10'd1;
        if (w_v_end) r_sel <= pattern_sel;
      end else begin
        r_hc <= r_hc + 10'd1;
        if (r_sub == c_BAR_LAST) begin
          r_sub <= 10'd0;
          r_bar <= r_bar + 3'd1;
        end else begin
          r_sub <= r_sub + 10'd1;
        end
      end
    end
  end

  assign w_x = {22'd0, r_hc};
  assign w_y = {22'd0, r_vc};

  assign w_white = (w_x == 0) || (w_x == H_ACTIVE - 1) || (w_y == 0) || (w_y == V_ACTIVE - 1) ||
                   (w_x == c_HC - 1) || (w_x == c_HC) || (w_y == c_VC - 1) || (w_y == c_VC) ||
                   f_outline(w_x, w_y, c_HC - 50, c_HC + 50, c_VC - 50, c_VC + 50) ||
                   f_outline(w_x, w_y, 16, H_ACTIVE - 17, 12, V_ACTIVE - 13);
  assign w_title = f_outline(w_x, w_y, 32, H_ACTIVE - 33, 24, V_ACTIVE - 25);
  assign w_grid  = w_white ? 8'd255 : (w_title ? 8'd127 : 8'd77);
  assign w_ramp  = {r_bar, 5'd0} + {3'd0, r_bar, 2'd0};
  assign w_check = (r_hc[3] ^ r_vc[3]) ? 8'd255 : 8'd0;

`ifdef SUITE_DRIFT_EN
  logic [9:0]  r_drift;
  logic [10:0] w_doff;

  // Advances on the wrap into a new frame so the bar is stable for the whole frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drift <= 10'd0;
    end else if (r_ce && w_h_end && w_v_end) begin
      r_drift <= (r_drift == c_HA - 10'd1) ? 10'd0 : r_drift + 10'd1;
    end
  end

  assign w_doff = (r_hc >= r_drift) ? {1'b0, r_hc - r_drift}
                                    : {1'b0, r_hc} + {1'b0, c_HA} - {1'b0, r_drift};
  assign w_flat = (w_doff < 11'd8) ? 8'd255 : 8'd77;
`else
  assign w_flat = 8'd255;
`endif

  always_comb begin
    w_luma = 8'd0;
    case (r_sel)
      2'd0:    w_luma = w_grid;
      2'd1:    w_luma = w_ramp;
      2'd2:    w_luma = w_check;
      default: w_luma = w_flat;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hblank <= 1'b0;
      r_hsync  <= 1'b0;
      r_vblank <= 1'b0;
      r_vsync  <= 1'b0;
      r_fstart <= 1'b0;
      r_video  <= 8'd0;
    end else if (r_ce) begin
      r_hblank <= (r_hc >= c_HA);
      r_hsync  <= (r_hc >= c_HS_START) && (r_hc < c_HS_END);
      r_vblank <= (r_vc >= c_VA);
      if (r_hc == c_HS_START) r_vsync <= (r_vc >= c_VS_START) && (r_vc < c_VS_END);
      r_fstart <= (r_hc == 10'd0) && (r_vc == 10'd0);
      r_video  <= w_blank ? 8'd0 : w_luma;
    end
  end

  assign ce_pix      = r_ce;
  assign HBlank      = r_hblank;
  assign HSync       = r_hsync;
  assign VBlank      = r_vblank;
  assign VSync       = r_vsync;
  assign frame_start = r_fstart;
  assign video       = r_video;

endmodule
`default_nettype wire

// File: tb/tb_suite_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_suite_pattern_gen
// Purpose  : Cycle-accurate check of suite_pattern_gen against a raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_suite_pattern_gen;

  localparam int CD  = 2;
  localparam int HA  = 104, HFP = 2, HS = 4, HBP = 2;
  localparam int VA  = 52,  VFP = 2, VS = 3, VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int P   = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] pattern_sel = 2'd0;
  logic       ce_pix, HBlank, HSync, VBlank, VSync, frame_start;
  logic [7:0] video;

  suite_pattern_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) u_dut (
    .clk(clk), .reset(reset), .pattern_sel(pattern_sel), .ce_pix(ce_pix),
    .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
    .frame_start(frame_start), .video(video)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   n;          // clock edges since reset release
  int   last_fs;
  logic prev_fs;
  int   fsel [0:15];
  int   plan [0:2] = '{2, 1, 3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_vs(input int v);
    return v >= VA + VFP && v < VA + VFP + VS;
  endfunction

  function automatic bit outline(input int x, input int y, input int l, input int r,
                                 input int t, input int b);
    return ((x == l || x == r) && y >= t && y <= b) || ((y == t || y == b) && x >= l && x <= r);
  endfunction

  function automatic int grid(input int x, input int y);
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 255;
    if (x == HA / 2 - 1 || x == HA / 2 || y == VA / 2 - 1 || y == VA / 2) return 255;
    if (outline(x, y, HA / 2 - 50, HA / 2 + 50, VA / 2 - 50, VA / 2 + 50)) return 255;
    if (outline(x, y, 16, HA - 17, 12, VA - 13)) return 255;
    if (outline(x, y, 32, HA - 33, 24, VA - 25)) return 127;
    return 77;
  endfunction

  function automatic int pix(input int sel, input int x, input int y, input int f);
    case (sel)
      0:       return grid(x, y);
      1:       return (x / (HA / 8)) * 36;
      2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 255 : 0;
`ifdef SUITE_DRIFT_EN
      default: return (((x - (f % HA) + HA) % HA) < 8) ? 255 : 77;
`else
      default: return (f >= 0) ? 255 : 255;
`endif
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, "_ce"},     ce_pix, 0);
    check_eq({tag, "_hblank"}, HBlank, 0);
    check_eq({tag, "_hsync"},  HSync, 0);
    check_eq({tag, "_vblank"}, VBlank, 0);
    check_eq({tag, "_vsync"},  VSync, 0);
    check_eq({tag, "_fstart"}, frame_start, 0);
    check_eq({tag, "_video"},  video, 0);
  endtask

  task automatic check_cycle();
    int k, hc, vc, ln, f;
    bit eh, ehs, evb, evs, efs;
    int ev;
    eh = 0; ehs = 0; evb = 0; evs = 0; efs = 0; ev = 0;
    if (n > CD) begin
      k   = (n - 1) / CD - 1;
      hc  = k % HT;
      ln  = k / HT;
      vc  = ln % VT;
      f   = ln / VT;
      eh  = hc >= HA;
      ehs = hc >= HA + HFP && hc < HA + HFP + HS;
      evb = vc >= VA;
      evs = (hc >= HA + HFP) ? in_vs(vc) : (ln > 0 && in_vs((ln - 1) % VT));
      efs = hc == 0 && vc == 0;
      ev  = (eh || evb) ? 0 : pix(fsel[f], hc, vc, f);
    end
    check_eq("ce_pix",      ce_pix, (n % CD) == 0);
    check_eq("HBlank",      HBlank, eh);
    check_eq("HSync",       HSync, ehs);
    check_eq("VBlank",      VBlank, evb);
    check_eq("VSync",       VSync, evs);
    check_eq("frame_start", frame_start, efs);
    check_eq("video",       video, ev);
  endtask

  // Randomises pattern_sel every line; the last line of a frame carries the planned value.
  task automatic drive();
    int k;
    if (n > 0 && n % CD == 0) begin
      k = n / CD - 1;
      if (k % HT == 0) begin
        if ((k / HT) % VT == VT - 1)
          pattern_sel = (k / P < 3) ? 2'(plan[k / P]) : 2'($urandom_range(0, 3));
        else
          pattern_sel = 2'($urandom_range(0, 3));
      end
      if (k % P == P - 1) fsel[k / P + 1] = int'(pattern_sel);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    check_cycle();
    if (frame_start === 1'b1 && prev_fs !== 1'b1) begin
      if (last_fs >= 0) check_eq("fs_period", n - last_fs, P * CD);
      last_fs = n;
    end
    prev_fs = frame_start;
    drive();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fsel[i] = 0;
    n = 0; last_fs = -1; prev_fs = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;

    repeat (3 * P * CD + 20 * HT * CD + 7) step();

    #2 reset = 1'b1;
    #1 check_zero("arst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("arst_hold");
    reset = 1'b0;
    n = 0; last_fs = -1; prev_fs = 1'b0;
    for (int i = 0; i < 16; i++) fsel[i] = 0;

    repeat (P * CD / 2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
